// File: rtl/axi_arb_pkg.sv
// Purpose: shared types and constants for the two-master AXI4-lite arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ownership state enum, AXI response codes, master index constants.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Master indices: fetch unit is master 0, load/store unit is master 1.
    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/axi_arb_pick.sv
// Purpose: picks which of the two requesting masters is granted the bus.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the result is only consumed when at least one req bit is set.
// Ports: req_i[1:0] pending requests, last_owner_i previous grant, winner_o granted index.
// Compile option ARB_RR_EN: round-robin tie break; otherwise the LSU wins ties.
module axi_arb_pick
    import axi_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic       winner_o
);

`ifdef ARB_RR_EN
    // Tie goes to whichever master did not hold the bus last.
    always_comb begin
        winner_o = M_IFU;
        case (req_i)
            2'b01:   winner_o = M_IFU;
            2'b10:   winner_o = M_LSU;
            2'b11:   winner_o = ~last_owner_i;
            default: winner_o = M_IFU;
        endcase
    end
`else
    // Fixed priority has no history; the input is kept only for a uniform port list.
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;

    always_comb begin
        winner_o = M_IFU;
        if (req_i[1]) begin
            winner_o = M_LSU;
        end
    end
`endif

endmodule

// File: rtl/axi_lite_arbiter.sv
// Purpose: two-master / one-slave AXI4-lite arbiter; one master owns the bus per transaction.
// Latency: 1 arbitration cycle from request to forwarded AR/AW; 1 IDLE cycle between transactions.
// Backpressure: slave ready/valid forwarded combinationally to the owner only; others see 0.
// Ports: clock, reset (sync, active-high); m0_*/m1_* master AR/R/AW/W/B channels; s_* slave channels.
// Compile option ARB_RR_EN: round-robin grant with a last-owner register; otherwise LSU priority.
module axi_lite_arbiter
    import axi_arb_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    // master 0 (fetch)
    input  logic [31:0] m0_araddr,
    input  logic [2:0]  m0_arsize,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    input  logic [31:0] m0_awaddr,
    input  logic [2:0]  m0_awsize,
    input  logic        m0_awvalid,
    output logic        m0_awready,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    input  logic        m0_wvalid,
    output logic        m0_wready,
    output logic [1:0]  m0_bresp,
    output logic        m0_bvalid,
    input  logic        m0_bready,
    // master 1 (load/store)
    input  logic [31:0] m1_araddr,
    input  logic [2:0]  m1_arsize,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    input  logic [31:0] m1_awaddr,
    input  logic [2:0]  m1_awsize,
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    output logic [1:0]  m1_bresp,
    output logic        m1_bvalid,
    input  logic        m1_bready,
    // slave
    output logic [31:0] s_araddr,
    output logic [2:0]  s_arsize,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready,
    output logic [31:0] s_awaddr,
    output logic [2:0]  s_awsize,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wvalid,
    input  logic        s_wready,
    input  logic [1:0]  s_bresp,
    input  logic        s_bvalid,
    output logic        s_bready
);

    state_e state_q, state_d;
    logic   is_write_q, is_write_d;
    // Address / write-data already accepted in this ownership: blocks a second
    // AR/AW/W from the owner leaking onto the slave before the response returns.
    logic   a_done_q, a_done_d;
    logic   w_done_q, w_done_d;

    logic [1:0] req;
    logic       winner;
    logic       last_owner;

    assign req = {m1_arvalid | m1_awvalid, m0_arvalid | m0_awvalid};

    axi_arb_pick u_pick (
        .req_i        (req),
        .last_owner_i (last_owner),
        .winner_o     (winner)
    );

`ifdef ARB_RR_EN
    logic last_owner_q, last_owner_d;

    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == IDLE && req != 2'b00) begin
            last_owner_d = winner;
        end
    end

    // Resets to the LSU so the fetch unit wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_owner_q <= M_LSU;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    assign last_owner = last_owner_q;
`else
    assign last_owner = M_LSU;
`endif

    // Owner's request signals, selected by current state.
    logic        own;
    logic        rd, wr;
    logic [31:0] sel_araddr, sel_awaddr, sel_wdata;
    logic [2:0]  sel_arsize, sel_awsize;
    logic [3:0]  sel_wstrb;
    logic        sel_arvalid, sel_awvalid, sel_wvalid, sel_rready, sel_bready;

    assign own = (state_q == OWN1);
    assign rd  = (state_q != IDLE) && !is_write_q;
    assign wr  = (state_q != IDLE) &&  is_write_q;

    always_comb begin
        sel_araddr  = own ? m1_araddr  : m0_araddr;
        sel_arsize  = own ? m1_arsize  : m0_arsize;
        sel_arvalid = own ? m1_arvalid : m0_arvalid;
        sel_rready  = own ? m1_rready  : m0_rready;
        sel_awaddr  = own ? m1_awaddr  : m0_awaddr;
        sel_awsize  = own ? m1_awsize  : m0_awsize;
        sel_awvalid = own ? m1_awvalid : m0_awvalid;
        sel_wdata   = own ? m1_wdata   : m0_wdata;
        sel_wstrb   = own ? m1_wstrb   : m0_wstrb;
        sel_wvalid  = own ? m1_wvalid  : m0_wvalid;
        sel_bready  = own ? m1_bready  : m0_bready;
    end

    // Values heading back to the owner before per-master steering.
    logic        f_arready, f_rvalid, f_awready, f_wready, f_bvalid;
    logic [31:0] f_rdata;
    logic [1:0]  f_rresp, f_bresp;

    always_comb begin
        s_araddr  = '0;
        s_arsize  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = '0;
        s_awsize  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        f_arready = 1'b0;
        f_rvalid  = 1'b0;
        f_rdata   = '0;
        f_rresp   = OKAY;
        f_awready = 1'b0;
        f_wready  = 1'b0;
        f_bvalid  = 1'b0;
        f_bresp   = OKAY;
        if (rd) begin
            s_araddr  = sel_araddr;
            s_arsize  = sel_arsize;
            s_arvalid = sel_arvalid && !a_done_q;
            f_arready = s_arready   && !a_done_q;
            s_rready  = sel_rready;
            f_rvalid  = s_rvalid;
            f_rdata   = s_rdata;
            f_rresp   = s_rresp;
        end
        if (wr) begin
            s_awaddr  = sel_awaddr;
            s_awsize  = sel_awsize;
            s_awvalid = sel_awvalid && !a_done_q;
            f_awready = s_awready   && !a_done_q;
            // W runs on its own handshake, ahead of or behind AW.
            s_wdata   = sel_wdata;
            s_wstrb   = sel_wstrb;
            s_wvalid  = sel_wvalid && !w_done_q;
            f_wready  = s_wready   && !w_done_q;
            s_bready  = sel_bready;
            f_bvalid  = s_bvalid;
            f_bresp   = s_bresp;
        end
    end

    always_comb begin
        m0_arready = 1'b0; m0_rvalid = 1'b0; m0_rdata = '0; m0_rresp = OKAY;
        m0_awready = 1'b0; m0_wready = 1'b0; m0_bvalid = 1'b0; m0_bresp = OKAY;
        m1_arready = 1'b0; m1_rvalid = 1'b0; m1_rdata = '0; m1_rresp = OKAY;
        m1_awready = 1'b0; m1_wready = 1'b0; m1_bvalid = 1'b0; m1_bresp = OKAY;
        if (state_q == OWN0) begin
            m0_arready = f_arready; m0_rvalid = f_rvalid; m0_rdata = f_rdata; m0_rresp = f_rresp;
            m0_awready = f_awready; m0_wready = f_wready; m0_bvalid = f_bvalid; m0_bresp = f_bresp;
        end
        if (state_q == OWN1) begin
            m1_arready = f_arready; m1_rvalid = f_rvalid; m1_rdata = f_rdata; m1_rresp = f_rresp;
            m1_awready = f_awready; m1_wready = f_wready; m1_bvalid = f_bvalid; m1_bresp = f_bresp;
        end
    end

    // Ownership FSM.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        a_done_d   = a_done_q || (s_arvalid && s_arready) || (s_awvalid && s_awready);
        w_done_d   = w_done_q || (s_wvalid && s_wready);
        case (state_q)
            IDLE: begin
                a_done_d = 1'b0;
                w_done_d = 1'b0;
                if (req != 2'b00) begin
                    state_d = winner ? OWN1 : OWN0;
                    // A master raising both AR and AW is served as a read first.
                    is_write_d = winner ? (!m1_arvalid && m1_awvalid)
                                        : (!m0_arvalid && m0_awvalid);
                end
            end
            OWN0, OWN1: begin
                if ((rd && s_rvalid && s_rready) || (wr && s_bvalid && s_bready)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            a_done_q   <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            a_done_q   <= a_done_d;
            w_done_q   <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
module tb_axi_lite_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] m0_araddr, m0_awaddr, m0_wdata, m0_rdata;
    logic [2:0]  m0_arsize, m0_awsize;
    logic [3:0]  m0_wstrb;
    logic [1:0]  m0_rresp, m0_bresp;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_awvalid, m0_awready;
    logic        m0_wvalid, m0_wready, m0_bvalid, m0_bready;
    logic [31:0] m1_araddr, m1_awaddr, m1_wdata, m1_rdata;
    logic [2:0]  m1_arsize, m1_awsize;
    logic [3:0]  m1_wstrb;
    logic [1:0]  m1_rresp, m1_bresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_awvalid, m1_awready;
    logic        m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
    logic [2:0]  s_arsize, s_awsize;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_rresp, s_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic        s_wvalid, s_wready, s_bvalid, s_bready;

    int tests_run = 0;
    int failed    = 0;

    always #5 clock = ~clock;

    axi_lite_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_araddr(m0_araddr), .m0_arsize(m0_arsize), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_awaddr(m0_awaddr), .m0_awsize(m0_awsize), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m1_araddr(m1_araddr), .m1_arsize(m1_arsize), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awsize(m1_awsize), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awsize(s_awsize), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    // Every DUT output of one endpoint gathered so "all zero" is one comparison.
    logic [40:0]  m0_o, m1_o;
    logic [110:0] s_o;
    assign m0_o = {m0_arready, m0_rdata, m0_rresp, m0_rvalid, m0_awready, m0_wready, m0_bresp, m0_bvalid};
    assign m1_o = {m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_awready, m1_wready, m1_bresp, m1_bvalid};
    assign s_o  = {s_araddr, s_arsize, s_arvalid, s_rready, s_awaddr, s_awsize, s_awvalid,
                   s_wdata, s_wstrb, s_wvalid, s_bready};

    // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        m0_araddr = '0; m0_arsize = '0; m0_arvalid = 0; m0_rready = 0;
        m0_awaddr = '0; m0_awsize = '0; m0_awvalid = 0; m0_wdata = '0; m0_wstrb = '0;
        m0_wvalid = 0; m0_bready = 0;
        m1_araddr = '0; m1_arsize = '0; m1_arvalid = 0; m1_rready = 0;
        m1_awaddr = '0; m1_awsize = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0;
        m1_wvalid = 0; m1_bready = 0;
        s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
        s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        step();
        m0_arvalid = 1; m0_araddr = 32'h0000_0040;
        step();
        #1;
        tests_run++;
        if ({m0_o, m1_o, s_o} !== '0) begin
            failed++; $display("FAIL reset_outputs: m0=%h m1=%h s=%h expected all 0", m0_o, m1_o, s_o);
        end
        m0_arvalid = 0; m0_araddr = '0;
        reset = 0;
        step();
    endtask

    task automatic test_read_m0();
        m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_arsize = 3'd2; m0_rready = 1;
        s_arready = 1;
        #1;
        tests_run++;
        if (s_arvalid !== 1'b0 || m0_arready !== 1'b0) begin
            failed++; $display("FAIL rd_grant_latency: s_arvalid=%0b m0_arready=%0b expected 0 0", s_arvalid, m0_arready);
        end
        step();
        #1;
        tests_run++;
        if ({s_arvalid, s_araddr, s_arsize, m0_arready, s_awvalid} !== {1'b1, 32'h8000_0000, 3'd2, 1'b1, 1'b0}) begin
            failed++; $display("FAIL rd_ar_fwd: got %0b %h %0d %0b %0b expected 1 80000000 2 1 0", s_arvalid, s_araddr, s_arsize, m0_arready, s_awvalid);
        end
        step();
        m0_arvalid = 0; s_arready = 0;
        s_bvalid = 1; s_bresp = 2'b10;
        #1;
        tests_run++;
        if ({s_bready, m0_bvalid, m0_bresp, m1_o} !== '0) begin
            failed++; $display("FAIL rd_spurious_b: s_bready=%0b m0_bvalid=%0b m0_bresp=%0d m1=%h expected all 0", s_bready, m0_bvalid, m0_bresp, m1_o);
        end
        step();
        s_bvalid = 0; s_bresp = 0;
        s_rvalid = 1; s_rdata = 32'h1234_5678; s_rresp = 2'b00;
        #1;
        tests_run++;
        if ({m0_rvalid, m0_rdata, m0_rresp, s_rready} !== {1'b1, 32'h1234_5678, 2'b00, 1'b1} || m1_o !== '0) begin
            failed++; $display("FAIL rd_r_fwd: got rvalid=%0b rdata=%h rresp=%0d s_rready=%0b m1=%h expected 1 12345678 0 1 0", m0_rvalid, m0_rdata, m0_rresp, s_rready, m1_o);
        end
        step();
        s_rvalid = 0; s_rdata = '0;
        m0_arvalid = 1; m0_araddr = 32'h8000_0004; s_arready = 1;
        #1;
        tests_run++;
        if ({m0_o, m1_o, s_o} !== '0) begin
            failed++; $display("FAIL rd_turnaround_idle: m0=%h m1=%h s=%h expected all 0", m0_o, m1_o, s_o);
        end
        step();
        #1;
        tests_run++;
        if ({s_arvalid, s_araddr, m0_arready} !== {1'b1, 32'h8000_0004, 1'b1}) begin
            failed++; $display("FAIL rd_back_to_back: got %0b %h %0b expected 1 80000004 1", s_arvalid, s_araddr, m0_arready);
        end
        step();
        m0_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h0000_0099;
        step();
        s_rvalid = 0; s_rdata = '0; m0_rready = 0;
    endtask

    task automatic test_write_m1();
        m1_awvalid = 1; m1_awaddr = 32'h1000_0000; m1_awsize = 3'd0;
        m1_wvalid = 1; m1_wdata = 32'h0000_00AB; m1_wstrb = 4'b0001; m1_bready = 1;
        s_wready = 1; s_arready = 1;
        step();
        #1;
        tests_run++;
        if ({s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_arvalid, m1_awready, m1_wready}
            !== {1'b1, 32'h1000_0000, 1'b1, 32'h0000_00AB, 4'b0001, 1'b0, 1'b0, 1'b1}) begin
            failed++; $display("FAIL wr_fwd: awv=%0b awaddr=%h wv=%0b wdata=%h wstrb=%b arv=%0b awr=%0b wr=%0b expected 1 10000000 1 000000ab 0001 0 0 1",
                s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_arvalid, m1_awready, m1_wready);
        end
        step();
        m1_wvalid = 0;
        #1;
        tests_run++;
        if ({s_awvalid, s_wvalid, s_arvalid, m1_awready} !== 4'b1000) begin
            failed++; $display("FAIL wr_aw_wait: awv=%0b wv=%0b arv=%0b awready=%0b expected 1 0 0 0", s_awvalid, s_wvalid, s_arvalid, m1_awready);
        end
        step();
        step();
        s_awready = 1;
        #1;
        tests_run++;
        if ({s_awvalid, m1_awready, s_arvalid} !== 3'b110) begin
            failed++; $display("FAIL wr_aw_ready: awv=%0b awready=%0b arv=%0b expected 1 1 0", s_awvalid, m1_awready, s_arvalid);
        end
        step();
        m1_awvalid = 0; s_awready = 0;
        s_bvalid = 1; s_bresp = 2'b10;
        #1;
        tests_run++;
        if ({m1_bvalid, m1_bresp, s_bready, s_awvalid, s_arvalid, m0_o} !== {1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 41'd0}) begin
            failed++; $display("FAIL wr_bresp: bvalid=%0b bresp=%0d s_bready=%0b awv=%0b arv=%0b m0=%h expected 1 2 1 0 0 0",
                m1_bvalid, m1_bresp, s_bready, s_awvalid, s_arvalid, m0_o);
        end
        step();
        s_bvalid = 0; s_bresp = 0; s_arready = 0; s_wready = 0; m1_bready = 0;
    endtask

    task automatic test_tie();
        logic exp_w;
        m0_rready = 1; m1_bready = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            exp_w = (i % 2 == 1);
`else
            exp_w = 1'b1;
`endif
            m0_arvalid = 1; m0_araddr = 32'h100 + i;
            m1_awvalid = 1; m1_awaddr = 32'h200 + i; m1_wvalid = 1; m1_wdata = 32'h300 + i; m1_wstrb = 4'hF;
            step();
            #1;
            tests_run++;
            if ({s_awvalid, s_arvalid} !== {exp_w, ~exp_w}) begin
                failed++; $display("FAIL tie_%0d: s_awvalid=%0b s_arvalid=%0b expected %0b %0b", i, s_awvalid, s_arvalid, exp_w, ~exp_w);
            end
            if (exp_w) begin
                s_awready = 1; s_wready = 1;
                step();
                m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 1;
                step();
                s_bvalid = 0;
            end else begin
                s_arready = 1;
                step();
                m0_arvalid = 0; s_arready = 0; s_rvalid = 1;
                step();
                s_rvalid = 0;
            end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_blocked_read();
        m1_awvalid = 1; m1_awaddr = 32'h2000_0000; m1_wvalid = 1; m1_wdata = 32'h5; m1_wstrb = 4'hF; m1_bready = 1;
        step();
        m0_arvalid = 1; m0_araddr = 32'hCAFE_0000; m0_arsize = 3'd2; m0_rready = 1;
        s_arready = 1; s_awready = 1; s_wready = 1;
        #1;
        tests_run++;
        if ({m0_arready, s_arvalid, m1_awready} !== 3'b001) begin
            failed++; $display("FAIL blk_during_write: m0_arready=%0b s_arvalid=%0b m1_awready=%0b expected 0 0 1", m0_arready, s_arvalid, m1_awready);
        end
        step();
        m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 1;
        #1;
        tests_run++;
        if ({m0_arready, s_arvalid, m1_bvalid} !== 3'b001) begin
            failed++; $display("FAIL blk_during_b: m0_arready=%0b s_arvalid=%0b m1_bvalid=%0b expected 0 0 1", m0_arready, s_arvalid, m1_bvalid);
        end
        step();
        s_bvalid = 0; m1_bready = 0;
        #1;
        tests_run++;
        if ({m0_arready, s_arvalid} !== 2'b00) begin
            failed++; $display("FAIL blk_idle_gap: m0_arready=%0b s_arvalid=%0b expected 0 0", m0_arready, s_arvalid);
        end
        step();
        #1;
        tests_run++;
        if ({s_arvalid, s_araddr, s_arsize, m0_arready} !== {1'b1, 32'hCAFE_0000, 3'd2, 1'b1}) begin
            failed++; $display("FAIL blk_addr_intact: got %0b %h %0d %0b expected 1 cafe0000 2 1", s_arvalid, s_araddr, s_arsize, m0_arready);
        end
        step();
        m0_arvalid = 0; s_arready = 0; s_rvalid = 1;
        step();
        clear_inputs();
    endtask

    task automatic test_spurious_idle();
        m0_rready = 1; m1_rready = 1; m0_bready = 1; m1_bready = 1;
        s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b10; s_bvalid = 1; s_bresp = 2'b10;
        #1;
        tests_run++;
        if ({s_rready, s_bready, m0_rvalid, m1_rvalid, m0_bvalid, m1_bvalid, m0_rdata, m1_rdata} !== '0) begin
            failed++; $display("FAIL spurious_idle: s_rready=%0b s_bready=%0b m0_rvalid=%0b m1_rvalid=%0b m0_rdata=%h expected 0 0 0 0 0",
                s_rready, s_bready, m0_rvalid, m1_rvalid, m0_rdata);
        end
        step();
        #1;
        tests_run++;
        if ({m0_o, m1_o, s_o} !== '0) begin
            failed++; $display("FAIL spurious_stays_idle: m0=%h m1=%h s=%h expected all 0", m0_o, m1_o, s_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_read();
        m0_arvalid = 1; m0_araddr = 32'h0000_0080; m0_rready = 1; s_arready = 1;
        step();
        step();
        m0_arvalid = 0; s_arready = 0;
        reset = 1; s_rvalid = 1; s_rdata = 32'h0BAD_0BAD;
        step();
        #1;
        tests_run++;
        if ({m0_o, m1_o, s_o} !== '0) begin
            failed++; $display("FAIL rst_mid_read: m0=%h m1=%h s=%h expected all 0", m0_o, m1_o, s_o);
        end
        reset = 0; s_rvalid = 0; s_rdata = '0;
        m1_arvalid = 1; m1_araddr = 32'h0000_0044; m1_rready = 1; s_arready = 1;
        step();
        #1;
        tests_run++;
        if ({s_arvalid, s_araddr, m1_arready, m0_arready} !== {1'b1, 32'h0000_0044, 1'b1, 1'b0}) begin
            failed++; $display("FAIL rst_then_m1: got %0b %h %0b %0b expected 1 00000044 1 0", s_arvalid, s_araddr, m1_arready, m0_arready);
        end
        step();
        m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h0000_0055;
        #1;
        tests_run++;
        if ({m1_rvalid, m1_rdata, m0_rvalid} !== {1'b1, 32'h0000_0055, 1'b0}) begin
            failed++; $display("FAIL rst_then_m1_r: rvalid=%0b rdata=%h m0_rvalid=%0b expected 1 00000055 0", m1_rvalid, m1_rdata, m0_rvalid);
        end
        step();
        clear_inputs();
        step();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        step();
        test_reset();
        test_read_m0();
        test_write_m1();
        test_tie();
        test_blocked_read();
        test_spurious_idle();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-master, one-slave AXI4-lite arbiter placed between the core's fetch unit (master 0) and load/store unit (master 1) and the single memory/peripheral bus. One master owns the bus for a whole transaction: AR→R for a read, AW→W→B for a write. Every slave channel is forwarded combinationally to the owner only. A 3-state FSM sequences ownership, and the grant policy is selectable at compile time.

## Interface
- No parameters. Address and data are fixed 32-bit, size 3-bit, resp 2-bit.
- clock  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- mN_araddr/mN_arsize/mN_arvalid  input  32/3/1  master N (N=0,1) read address
- mN_arready  output  1  read address accept to master N
- mN_rdata/mN_rresp/mN_rvalid  output  32/2/1  read data to master N
- mN_rready  input  1  master N read-data ready
- mN_awaddr/mN_awsize/mN_awvalid  input  32/3/1  master N write address
- mN_awready  output  1
- mN_wdata/mN_wstrb/mN_wvalid  input  32/4/1  master N write data
- mN_wready  output  1
- mN_bresp/mN_bvalid  output  2/1  write response to master N
- mN_bready  input  1
- s_araddr/s_arsize/s_arvalid  output  32/3/1  slave read address
- s_arready  input  1
- s_rdata/s_rresp/s_rvalid  input  32/2/1
- s_rready  output  1
- s_awaddr/s_awsize/s_awvalid  output  32/3/1
- s_awready  input  1
- s_wdata/s_wstrb/s_wvalid  output  32/4/1
- s_wready  input  1
- s_bresp/s_bvalid  input  2/1
- s_bready  output  1

## Operation
- State register: IDLE, OWN0, OWN1. Flag is_write is registered at grant.
- Request of master N: mN_arvalid | mN_awvalid.
- IDLE, no request: stay.
- IDLE, requests present: go to OWNk for the chosen master k.
  - is_write <= ~mk_arvalid & mk_awvalid, so read wins when a master raises both.
- OWNk, read (is_write=0):
  - AR and R channels pass through between master k and the slave.
  - s_awvalid and s_wvalid are held at 0.
- OWNk, write (is_write=1):
  - AW, W and B channels pass through.
  - s_arvalid is held at 0.
  - W is forwarded independently of AW ordering.
- OWNk exits to IDLE on the cycle after the final handshake: s_rvalid&s_rready for a read, s_bvalid&s_bready for a write.
- The non-owner, and every master while in IDLE, sees all ready and valid outputs at 0. Its requests stay pending.
- Slave rvalid/bvalid arriving in IDLE, or on the channel not matching is_write, is not forwarded and not acked (s_rready/s_bready = 0).
- rresp/bresp pass through unmodified. The arbiter never generates errors.
- Mux/data outputs to inactive endpoints are 0.

## Timing
- Reset: state=IDLE, is_write=0. All valid/ready outputs are 0 in the cycle after reset is sampled high. Reset mid-transaction drops ownership; the slave is reset by the same signal.
- Grant latency: a request visible in IDLE at edge t gets forwarded s_arvalid/s_awvalid from cycle t+1.
  - Best-case read is 1 arbitration cycle plus slave latency.
- Turnaround: exactly one IDLE cycle between consecutive transactions, including back-to-back requests from the same master.
- Masters hold valid until ready, per AXI. The arbiter never drops a forwarded valid before its handshake.

## Configuration
- ARB_RR_EN defined: round-robin policy.
  - A 1-bit last-owner register is updated on every grant and resets to 1, so master 0 wins the first tie.
  - On a tie, the master that was not last owner wins.
- ARB_RR_EN undefined: fixed priority, master 1 (LSU) always wins a tie. No last-owner register exists.

## Structure
- Package axi_arb_pkg holds:
  - state enum {IDLE, OWN0, OWN1}
  - resp constants OKAY=2'b00, SLVERR=2'b10
  - master index localparams M_IFU=0, M_LSU=1
- Sub-module axi_arb_pick (combinational): inputs req[1:0] and last_owner, output the winner index. It contains the ARB_RR_EN policy, so the top FSM is policy-free.

## Test plan
- m0 read only, addr 0x8000_0000, slave arready=1, rdata 0x1234_5678 after 2 cycles -> m0 gets rdata 0x1234_5678, rresp 0. m1 outputs stay 0 throughout. State returns to IDLE one cycle after the R handshake.
- m1 write with wait states: awaddr 0x1000_0000, wdata 0xAB, wstrb 4'b0001, awready delayed 3 cycles, bresp 2'b10 -> W forwarded unchanged; m1 receives bresp 2'b10; no s_arvalid seen.
- Simultaneous m0 read and m1 write in IDLE, repeated 4 times:
  - fixed priority: m1 wins every time.
  - ARB_RR_EN: grants alternate m0, m1, m0, m1.
- m0 raises arvalid while m1 owns the bus -> m0_arready stays 0 until m1's B handshake plus 1 IDLE cycle; m0's address is then forwarded intact.
- Spurious s_rvalid=1 in IDLE -> s_rready=0, no master sees rvalid.
- Reset asserted mid-read after the AR handshake -> next cycle state is IDLE and all valid/ready outputs are 0. A new m1 request afterwards is granted normally.
